vga_line_buffer: RTL

Double-banked scanline buffer that sits directly upstream of the VGA timing/output stage.
- A pixel producer (pattern generator, DMA, CPU) streams one line of 8-bit RGB332 pixels over a valid/ready handshake.
- The timing stage reads those pixels back at pixel rate during active video.
- Banks swap at each line start, so the producer has a whole line period to fill the next line.

---
 rtl/vga_line_buffer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/vga_line_buffer.sv
// Double-banked RGB332 scanline buffer between a pixel producer and the VGA timing stage.
// Optional build macro VGA_LB_PIXDBL_EN enables horizontal pixel doubling (half-width fill).
module vga_line_buffer #(
    parameter int LINE_PIXELS = 1024,
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              line_start,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              underrun,
    input  logic              underrun_clr
);

    typedef enum logic [0:0] {
        FILL      = 1'b0,
        WAIT_SWAP = 1'b1
    } wr_state_t;

`ifdef VGA_LB_PIXDBL_EN
    localparam int FILL_PIXELS = LINE_PIXELS / 2;
`else
    localparam int FILL_PIXELS = LINE_PIXELS;
`endif
    // Last stored address of a line; also where the read pointer saturates.
    localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(FILL_PIXELS - 1);

    logic [DATA_W-1:0] bank_mem [0:1][0:LINE_PIXELS-1];

    wr_state_t         wr_state_r;
    logic              wr_ready_r;
    logic              wr_sel_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic              rd_bank_ok_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              rd_valid_r;
    logic              underrun_r;

    logic wr_fire_s;
    logic last_beat_s;
    logic swap_s;
    logic rd_step_s;

    assign wr_fire_s   = wr_valid && (wr_state_r == FILL);
    assign last_beat_s = wr_fire_s && (wr_addr_r == FILL_LAST);
    // A final beat landing with line_start still completes the line in time.
    assign swap_s      = line_start && ((wr_state_r == WAIT_SWAP) || last_beat_s);

`ifdef VGA_LB_PIXDBL_EN
    logic rd_phase_r;
    assign rd_step_s = rd_phase_r;

    // Pixel-doubling phase: the read pointer advances on every second accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_phase_r <= 1'b0;
        end else if (line_start) begin
            rd_phase_r <= 1'b0;
        end else if (rd_en) begin
            rd_phase_r <= ~rd_phase_r;
        end
    end
`else
    assign rd_step_s = 1'b1;
`endif

    // Write FSM: fills the write bank, then waits for the line-start swap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_r   <= FILL;
            wr_ready_r   <= 1'b1;
            wr_sel_r     <= 1'b0;
            wr_addr_r    <= {ADDR_W{1'b0}};
            rd_bank_ok_r <= 1'b0;
        end else if (swap_s) begin
            wr_state_r   <= FILL;
            wr_ready_r   <= 1'b1;
            wr_sel_r     <= ~wr_sel_r;
            wr_addr_r    <= {ADDR_W{1'b0}};
            rd_bank_ok_r <= 1'b1;
        end else begin
            case (wr_state_r)
                FILL: begin
                    if (wr_fire_s) begin
                        wr_addr_r <= wr_addr_r + 1'b1;
                        if (last_beat_s) begin
                            wr_state_r <= WAIT_SWAP;
                            wr_ready_r <= 1'b0;
                        end
                    end
                end
                WAIT_SWAP: begin
                    wr_ready_r <= 1'b0;
                end
                default: begin
                    wr_state_r <= FILL;
                    wr_ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Pixel storage write port (contents need no reset; rd_bank_ok masks stale data).
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            bank_mem[wr_sel_r][wr_addr_r] <= wr_data;
        end
    end

    // Read path: synchronous read of the read bank with a saturating pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_r  <= {ADDR_W{1'b0}};
            rd_data_r  <= {DATA_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else if (line_start) begin
            rd_addr_r  <= {ADDR_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else if (rd_en) begin
            rd_valid_r <= 1'b1;
            rd_data_r  <= rd_bank_ok_r ? bank_mem[~wr_sel_r][rd_addr_r] : {DATA_W{1'b0}};
            if (rd_step_s && (rd_addr_r != FILL_LAST)) begin
                rd_addr_r <= rd_addr_r + 1'b1;
            end
        end else begin
            rd_valid_r <= 1'b0;
        end
    end

    // Sticky underrun flag; clear wins over a simultaneous set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_r <= 1'b0;
        end else if (underrun_clr) begin
            underrun_r <= 1'b0;
        end else if (line_start && !swap_s) begin
            underrun_r <= 1'b1;
        end
    end

    assign wr_ready = wr_ready_r;
    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign underrun = underrun_r;

endmodule
